// File: rtl/uart_pkg.sv
// Shared UART constants and types for the RX/TX datapaths and the RX byte FIFO.
// Pure definitions: no logic, no latency, no flow control.
package uart_pkg;

  localparam int CLK_FREQ_HZ     = 50_000_000;
  localparam int BAUD_RATE       = 115_200;
  localparam int CLKS_PER_BIT    = CLK_FREQ_HZ / BAUD_RATE;
  localparam int RX_SAMPLE_POINT = CLKS_PER_BIT / 2;

  localparam int DATA_WIDTH      = 8;
  localparam int RX_FIFO_DEPTH   = 8;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/rise_det.sv
// Registered rising-edge detector: combinational pulse on the first high cycle of d.
// The history register resets to 1, so a level already high at reset release is not an edge.
module rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 1'b1;
    end else begin
      d_q <= d;
    end
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/rx_byte_fifo.sv
// RX byte FIFO: one write per rx_end rising edge, first-word-fall-through read, 1-clk write-to-valid.
// No backpressure toward RX: a byte arriving while full (without a same-cycle read) is dropped and flagged.
module rx_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = RX_FIFO_DEPTH,
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_end,
  input  logic [WIDTH-1:0]         rx_dq,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic wr_stb;
  logic empty;
  logic do_rd;
  logic do_wr;
  logic drop;

  rise_det u_rise_det (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_end),
    .pulse (wr_stb)
  );

  // Extra pointer bit distinguishes full (MSBs differ) from empty (identical).
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_valid = ~empty;
  assign count    = wr_ptr - rd_ptr;
  assign rd_data  = mem[rd_ptr[AW-1:0]];

  assign do_rd = rd_valid & rd_ready;
  assign do_wr = wr_stb & (~full | do_rd);
  assign drop  = wr_stb & full & ~do_rd;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= rx_dq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // A new drop outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Bench for rx_byte_fifo: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a queue-based model.
module tb_rx_byte_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             rx_end   = 1'b0;
  logic [WIDTH-1:0] rx_dq    = '0;
  logic             rd_ready = 1'b0;
  logic             ovf_clr  = 1'b0;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic [3:0]       count;
  logic             full;
  logic             overflow;

  int errors = 0;
  int checks = 0;

  int mq[$];
  bit m_prev = 1'b1;
  bit m_ovf  = 1'b0;
  bit m_wr, m_rd, m_drop;
  int m_sz;
  bit cmp_en = 1'b0;

  int rd_pct[4] = '{10, 50, 90, 30};

  rx_byte_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_end   (rx_end),
    .rx_dq    (rx_dq),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .count    (count),
    .full     (full),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] b);
    rx_dq  = b;
    rx_end = 1'b1;
    tick();
    rx_end = 1'b0;
    tick();
  endtask

  task automatic read_expect(input string name, input logic [7:0] exp);
    check(name, rd_data, exp);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  // Model: a byte queue; a write happens when rx_end is high now and was low last cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_prev = 1'b1;
      m_ovf  = 1'b0;
    end else begin
      m_wr   = rx_end && !m_prev;
      m_prev = rx_end;
      m_sz   = mq.size();
      m_rd   = (m_sz > 0) && rd_ready;
      m_drop = m_wr && (m_sz == DEPTH) && !m_rd;
      if (m_rd) void'(mq.pop_front());
      if (m_wr && !m_drop) mq.push_back(int'(rx_dq));
      if (m_drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      check("m_rd_valid", rd_valid, mq.size() > 0);
      check("m_count",    count,    mq.size());
      check("m_full",     full,     mq.size() == DEPTH);
      check("m_overflow", overflow, m_ovf);
      if (mq.size() > 0) check("m_rd_data", rd_data, mq[0]);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #12;
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_count",    count,    4'd0);
    check("rst_full",     full,     1'b0);
    check("rst_overflow", overflow, 1'b0);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Single byte, 1-clk write-to-valid
    rx_dq  = 8'hA5;
    rx_end = 1'b1;
    #1 check("a5_valid_before", rd_valid, 1'b0);
    tick();
    check("a5_valid",  rd_valid, 1'b1);
    check("a5_data",   rd_data,  8'hA5);
    check("a5_count",  count,    4'd1);
    rx_end = 1'b0;
    tick();
    read_expect("a5_read", 8'hA5);
    check("a5_empty", rd_valid, 1'b0);

    // Held-high rx_end writes once
    rx_dq  = 8'h3C;
    rx_end = 1'b1;
    repeat (20) tick();
    check("hold_count", count, 4'd1);
    rx_end = 1'b0;
    tick();
    read_expect("hold_read", 8'h3C);
    check("hold_empty_count", count, 4'd0);

    // Fill, then drop the ninth byte
    for (int i = 1; i <= 9; i++) begin
      pulse(8'(i));
      if (i == 8) begin
        check("fill_full",     full,     1'b1);
        check("fill_ovf_pre",  overflow, 1'b0);
      end
    end
    check("drop_overflow", overflow, 1'b1);
    check("drop_count",    count,    4'd8);
    for (int i = 1; i <= 8; i++) read_expect("fill_read", 8'(i));
    check("fill_drained", rd_valid, 1'b0);

    // Clear with no drop
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 1'b0);

    // Clear coincident with a drop: set wins
    for (int i = 1; i <= 8; i++) pulse(8'h10 + 8'(i));
    check("refill_full", full, 1'b1);
    rx_dq   = 8'hEE;
    rx_end  = 1'b1;
    ovf_clr = 1'b1;
    tick();
    rx_end  = 1'b0;
    ovf_clr = 1'b0;
    check("ovf_set_wins", overflow, 1'b1);
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared2", overflow, 1'b0);

    // Full with simultaneous write and read
    rx_dq    = 8'h77;
    rx_end   = 1'b1;
    rd_ready = 1'b1;
    tick();
    rx_end   = 1'b0;
    rd_ready = 1'b0;
    check("wr_rd_full_count", count,    4'd8);
    check("wr_rd_full_full",  full,     1'b1);
    check("wr_rd_full_ovf",   overflow, 1'b0);
    tick();
    for (int i = 2; i <= 8; i++) read_expect("wr_rd_read", 8'h10 + 8'(i));
    read_expect("wr_rd_last", 8'h77);
    check("wr_rd_drained", rd_valid, 1'b0);

    // Mid-cycle reset with bytes stored, rx_end high at release
    pulse(8'hAA);
    pulse(8'hBB);
    pulse(8'hCC);
    check("pre_rst_count", count, 4'd3);
    @(posedge clk);
    #3;
    rx_end = 1'b1;
    rst_n  = 1'b0;
    #1;
    check("mid_rst_valid", rd_valid, 1'b0);
    check("mid_rst_count", count,    4'd0);
    check("mid_rst_full",  full,     1'b0);
    check("mid_rst_ovf",   overflow, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    tick();
    check("release_count", count,    4'd0);
    check("release_valid", rd_valid, 1'b0);
    rx_end = 1'b0;
    tick();
    pulse(8'h5A);
    check("post_rst_count", count, 4'd1);
    read_expect("post_rst_read", 8'h5A);

    // Randomized traffic, several read-pressure phases, occasional async reset
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 1000; c++) begin
        rx_end   = 1'($urandom_range(0, 1));
        rx_dq    = 8'($urandom);
        rd_ready = ($urandom_range(0, 99) < rd_pct[ph]);
        ovf_clr  = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 399) == 0) begin
          #2 rst_n = 1'b0;
          #3 rst_n = 1'b1;
        end
        tick();
      end
    end

    rx_end   = 1'b0;
    rd_ready = 1'b0;
    ovf_clr  = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_byte_fifo.md
RX_BYTE_FIFO -- requirements
Module: rx_byte_fifo

Interface
REQ-001 SHALL have parameter: DEPTH, 8, number of byte entries; power of 2, at least 2.
REQ-002 SHALL have parameter: WIDTH, 8, data width; matches the RX DQ width.
REQ-003 SHALL have port: clk  input  1  single system clock; all logic on posedge clk.
REQ-004 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port: rx_end  input  1  RX frame-complete level from the RX stage; synchronous to clk.
REQ-006 SHALL have port: rx_dq  input  WIDTH  received byte from the RX stage; stable while rx_end is high.
REQ-007 SHALL have port: rd_valid  output  1  FIFO holds at least one byte.
REQ-008 SHALL have port: rd_ready  input  1  consumer accepts rd_data this cycle.
REQ-009 SHALL have port: rd_data  output  WIDTH  head byte; first-word-fall-through.
REQ-010 SHALL have port: count  output  $clog2(DEPTH)+1  number of stored bytes.
REQ-011 SHALL have port: full  output  1  count == DEPTH.
REQ-012 SHALL have port: overflow  output  1  sticky flag: byte dropped while full.
REQ-013 SHALL have port: ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-014 SHALL generate a write strobe for exactly one cycle on each rx_end rising edge (rx_end=1, previous-cycle rx_end=0); a held-high rx_end SHALL NOT produce further writes.
REQ-015 SHALL capture rx_dq into mem[wr_ptr] in the same cycle as the write strobe; wr_ptr then increments modulo DEPTH.
REQ-016 SHALL complete a read handshake on a cycle where rd_valid && rd_ready; rd_ptr then increments modulo DEPTH.
REQ-017 SHALL drive rd_data = mem[rd_ptr] combinationally from storage; the value is don't-care when rd_valid=0.
REQ-018 SHALL raise rd_valid on the cycle after the write strobe into an empty FIFO; write-to-valid latency is 1 clk.
REQ-019 SHALL update count by +1 on write-only, -1 on read-only, and 0 on simultaneous write and read or on no event.
REQ-020 SHALL, when full and the write strobe fires without a read, drop the byte, leave pointers and count unchanged, and set overflow on the next cycle.
REQ-021 SHALL, when full with a simultaneous write strobe and read handshake, accept both; count stays DEPTH and overflow is not set.
REQ-022 SHALL, when empty with a write strobe and rd_ready=1, perform the write only; no read occurs because rd_valid=0.
REQ-023 SHALL clear overflow when ovf_clr=1; if ovf_clr and a new drop occur in the same cycle, set wins.
REQ-024 SHALL ignore rd_ready while rd_valid=0; no pointer underflow is permitted.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, full=0, overflow=0, and the edge-detect register=1.
REQ-026 SHALL, with the edge-detect register reset to 1, not record an rx_end that is already high at reset release as a write.
REQ-027 SHALL NOT reset storage contents; rd_data is don't-care after reset.
REQ-028 SHALL, on rst_n assertion mid-operation, discard all stored bytes; no partial write completes.

Structure
REQ-029 SHALL take the WIDTH default (8) and the DEPTH default (8) from shared package uart_pkg, alongside the existing RX/TX constants.
REQ-030 SHALL contain one sub-module, rise_det (1-bit registered rising-edge detector with asynchronous active-low reset, reset value 1); the FIFO core stays inline.
REQ-031 SHALL use ($clog2(DEPTH)+1)-bit pointers so that full and empty are derived from pointer MSB comparison, consistent with count.

Verification
REQ-032 SHALL cover: reset, then rx_end pulse with rx_dq=0xA5 -> rd_valid=1 one cycle later, rd_data=0xA5, count=1.
REQ-033 SHALL cover: rx_end held high for 20 cycles with rx_dq=0x3C -> exactly one write, count=1.
REQ-034 SHALL cover: 9 pulses of bytes 0x01..0x09 with rd_ready=0 -> full=1 after the 8th, overflow=1 after the 9th, reads return 0x01..0x08, and 0x09 never appears.
REQ-035 SHALL cover: full FIFO, write strobe (0x77) coincident with a read -> count stays 8, overflow=0, 0x77 read last.
REQ-036 SHALL cover: 3 bytes stored, rst_n pulsed low mid-cycle -> rd_valid, count, full, and overflow all 0 immediately; rx_end high at release causes no write.
REQ-037 SHALL cover: overflow set, ovf_clr=1 for one cycle with no drop -> overflow=0; ovf_clr coincident with a drop -> overflow=1.
